// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, sizes and helper functions for the 4x4 matrix
//               keypad scanner (state encoding, row/column index widths,
//               key-code mapping, column drive decode, lowest-low-row pick).
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KEY_W  = 4;
  localparam int ROW_IW = $clog2(ROWS);
  localparam int COL_IW = $clog2(COLS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Key code is row-major: row*COLS + col.
  function automatic logic [KEY_W-1:0] key_code_of(input logic [ROW_IW-1:0] row,
                                                   input logic [COL_IW-1:0] col);
    return KEY_W'(int'(row) * COLS + int'(col));
  endfunction

  // One-hot active-low column drive for a column index.
  function automatic logic [COLS-1:0] col_drive(input logic [COL_IW-1:0] idx);
    return ~(COLS'(1) << idx);
  endfunction

  // Index of the lowest-numbered row that is pulled low; 0 when none is low.
  function automatic logic [ROW_IW-1:0] lowest_low(input logic [ROWS-1:0] r);
    logic [ROW_IW-1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = ROW_IW'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_if
// Description : Key delivery bus between the keypad scanner and the
//               application. key_code/key_valid form a valid/ready holding
//               register; key_held and overrun are status outputs.
// Ports       : key_code  [KEY_W] accepted key (row*4 + col)
//               key_valid         key_code holds an unconsumed key
//               key_ready         consumer accepts key when both high
//               key_held          debounced key currently pressed
//               overrun           one-cycle pulse on a dropped key
//               modport master : scanner side, modport slave : consumer side
// Revision    : 1.0  initial release
// ============================================================================
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             key_held;
  logic             overrun;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready,
    output key_held,
    output overrun
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready,
    input  key_held,
    input  overrun
  );

endinterface
`default_nettype wire

// File: rtl/keypad_scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : keypad_tick
// Description : Scan-rate prescaler. Counts 0 .. SCAN_DIV-1 and wraps;
//               tick is high for the one clk cycle where the count is
//               SCAN_DIV-1.
// Ports       : clk      system clock
//               reset_n  asynchronous active-low reset
//               tick     scan tick strobe
// Revision    : 1.0  initial release
// ============================================================================
module keypad_tick #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 active-low matrix keypad scanner. Drives one column low
//               at a time, samples synchronized rows on scan ticks, debounces
//               a single press/release and offers the key code through a
//               valid/ready holding register.
//               Optional auto-repeat enabled by macro KEYPAD_SCAN_REPEAT_EN.
// Ports       : clk      system clock
//               reset_n  asynchronous active-low reset
//               row_n    [4] keypad rows, active-low, asynchronous
//               col_n    [4] one-hot active-low column drive
//               key_if   keypad_scan_if.master (key_code, key_valid,
//                        key_ready, key_held, overrun)
// Revision    : 1.0  initial release
// ============================================================================
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 50_000,
  parameter int DB_CNT      = 20,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  keypad_scan_if.master     key_if
);

  localparam int DB_W = $clog2(DB_CNT + 1);

  logic              tick;
  logic [ROWS-1:0]   rs_meta;
  logic [ROWS-1:0]   rs;

  state_t            state, state_n;
  logic [COL_IW-1:0] col_idx, col_idx_n;
  logic [ROW_IW-1:0] cand_row, cand_row_n;
  logic [DB_W-1:0]   db_cnt, db_cnt_n;
  logic              held_n;
  logic              offer;
  logic              enter_pressed;
  logic              rpt_fire;

  logic              any_low;
  logic              cand_low;
  logic              db_last;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Two-flop synchronizer; rows idle high through board pull-ups.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_meta <= '1;
      rs      <= '1;
    end else begin
      rs_meta <= row_n;
      rs      <= rs_meta;
    end
  end

  assign any_low  = (rs != '1);
  assign cand_low = !rs[cand_row];
  // db_cnt is about to reach DB_CNT on this tick.
  assign db_last  = (db_cnt == DB_W'(DB_CNT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= SCAN;
      col_idx         <= '0;
      col_n           <= col_drive('0);
      cand_row        <= '0;
      db_cnt          <= '0;
      key_if.key_held <= 1'b0;
    end else begin
      state           <= state_n;
      col_idx         <= col_idx_n;
      col_n           <= col_drive(col_idx_n);
      cand_row        <= cand_row_n;
      db_cnt          <= db_cnt_n;
      key_if.key_held <= held_n;
    end
  end

  always_comb begin
    state_n       = state;
    col_idx_n     = col_idx;
    cand_row_n    = cand_row;
    db_cnt_n      = db_cnt;
    held_n        = key_if.key_held;
    offer         = 1'b0;
    enter_pressed = 1'b0;

    if (tick) begin
      unique case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_n = col_idx + 1'b1;
          end else begin
            // Column stays frozen on the candidate until the release completes.
            cand_row_n = lowest_low(rs);
            db_cnt_n   = DB_W'(1);
            if (DB_CNT == 1) begin
              state_n       = PRESSED;
              held_n        = 1'b1;
              offer         = 1'b1;
              enter_pressed = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end

        DEBOUNCE: begin
          if (any_low && (lowest_low(rs) == cand_row)) begin
            db_cnt_n = db_cnt + 1'b1;
            if (db_last) begin
              state_n       = PRESSED;
              held_n        = 1'b1;
              offer         = 1'b1;
              enter_pressed = 1'b1;
            end
          end else begin
            state_n = SCAN;
          end
        end

        PRESSED: begin
          if (!cand_low) begin
            db_cnt_n = DB_W'(1);
            if (DB_CNT == 1) begin
              state_n   = SCAN;
              col_idx_n = col_idx + 1'b1;
              held_n    = 1'b0;
            end else begin
              state_n = RELEASE;
            end
          end else begin
            offer = rpt_fire;
          end
        end

        RELEASE: begin
          if (!cand_low) begin
            db_cnt_n = db_cnt + 1'b1;
            if (db_last) begin
              state_n   = SCAN;
              col_idx_n = col_idx + 1'b1;
              held_n    = 1'b0;
            end
          end else begin
            // Bounce back to pressed without re-offering the key.
            state_n = PRESSED;
          end
        end

        default: state_n = SCAN;
      endcase
    end
  end

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_inc;
  logic [RPT_W-1:0] rpt_limit;
  logic             rpt_phase;   // 0: waiting initial delay, 1: repeating

  assign rpt_inc   = rpt_cnt + 1'b1;
  assign rpt_limit = rpt_phase ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DLY);
  assign rpt_fire  = tick && (state == PRESSED) && cand_low && (rpt_inc == rpt_limit);

  // Cleared only on entry from the debounce path, so a release bounce
  // (PRESSED->RELEASE->PRESSED) keeps the accumulated delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (enter_pressed) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (tick && (state == PRESSED) && cand_low) begin
      if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_inc;
      end
    end
  end
`else
  logic unused_repeat;

  assign rpt_fire      = 1'b0;
  assign unused_repeat = ^{enter_pressed, 32'(REPEAT_DLY), 32'(REPEAT_RATE)};
`endif

  // Holding register: reload (on free slot or same-cycle consume) wins over
  // clear; an offer that finds the slot full is dropped with an overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_if.key_code  <= '0;
      key_if.key_valid <= 1'b0;
      key_if.overrun   <= 1'b0;
    end else begin
      key_if.overrun <= 1'b0;
      if (offer) begin
        if (!key_if.key_valid || key_if.key_ready) begin
          key_if.key_code  <= key_code_of(cand_row_n, col_idx);
          key_if.key_valid <= 1'b1;
        end else begin
          key_if.overrun <= 1'b1;
        end
      end else if (key_if.key_valid && key_if.key_ready) begin
        key_if.key_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan
// Description : Self-checking bench for keypad_scan with SCAN_DIV=4,
//               DB_CNT=3 (REPEAT_DLY=5, REPEAT_RATE=2 for the repeat build,
//               macro KEYPAD_SCAN_REPEAT_EN). Each table row is one scan
//               tick period: rows are applied just after a tick edge,
//               key_ready is raised only for the cycle ending on the next
//               tick edge, and outputs are compared just after that edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

  localparam logic [3:0] NK = 4'b1111;  // no row low
  localparam logic [3:0] R0 = 4'b1110;
  localparam logic [3:0] R1 = 4'b1101;
  localparam logic [3:0] R2 = 4'b1011;
  localparam logic [3:0] R3 = 4'b0111;
  localparam logic [3:0] C0 = 4'b1110;
  localparam logic [3:0] C1 = 4'b1101;
  localparam logic [3:0] C2 = 4'b1011;
  localparam logic [3:0] C3 = 4'b0111;

  typedef struct {
    logic [3:0] row_n;
    logic       rdy;
    logic [3:0] col_n;
    logic       valid;
    logic [3:0] code;
    logic       held;
    logic       ovr;
  } vec_t;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_n   = NK;
  logic [3:0] col_n;
  logic [3:0] prev_col;

  int n_pass  = 0;
  int n_total = 0;

  vec_t tbl[$];

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV    (4),
    .DB_CNT      (3),
    .REPEAT_DLY  (5),
    .REPEAT_RATE (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .row_n   (row_n),
    .col_n   (col_n),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [3:0] act,
                     input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): actual=%b required=%b", name, step, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic [3:0] c,
                              input logic v, input logic [3:0] k, input logic h,
                              input logic o);
    vec_t t;
    t.row_n = r; t.rdy = rd; t.col_n = c; t.valid = v;
    t.code  = k; t.held = h; t.ovr = o;
    return t;
  endfunction

  // One scan tick period; caller is positioned just after a tick edge.
  task automatic run_step(input vec_t v, input int step);
    row_n         = v.row_n;
    kif.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("col_n_mid", step, col_n, prev_col);
    kif.key_ready = v.rdy;
    @(posedge clk);
    #1;
    kif.key_ready = 1'b0;
    chk("col_n", step, col_n, v.col_n);
    chk("key_valid", step, {3'b0, kif.key_valid}, {3'b0, v.valid});
    chk("key_code", step, kif.key_code, v.code);
    chk("key_held", step, {3'b0, kif.key_held}, {3'b0, v.held});
    chk("overrun", step, {3'b0, kif.overrun}, {3'b0, v.ovr});
    prev_col = v.col_n;
  endtask

  initial begin
    int hs;
    int exp_hs;

    kif.key_ready = 1'b0;

    // row, rdy, col_n, valid, code, held, overrun
    // idle scan
    tbl.push_back(mk(NK, 1'b0, C1, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C3, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C0, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b0, 4'd0, 1'b0, 1'b0));
    // row 2 on column 1 -> key 9, then consume, then release
    tbl.push_back(mk(R2, 1'b0, C1, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(R2, 1'b0, C1, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(R2, 1'b0, C1, 1'b1, 4'd9, 1'b1, 1'b0));
    tbl.push_back(mk(R2, 1'b1, C1, 1'b0, 4'd9, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b0, 4'd9, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b0, 4'd9, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b0, 4'd9, 1'b0, 1'b0));
    // single-tick glitch on row 0 at column 2
    tbl.push_back(mk(R0, 1'b0, C2, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C3, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C0, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b0, 4'd9, 1'b0, 1'b0));
    // key 5 (row1,col1), not consumed
    tbl.push_back(mk(R1, 1'b0, C1, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C1, 1'b0, 4'd9, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C1, 1'b1, 4'd5, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b1, 4'd5, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b1, 4'd5, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    // key 6 (row1,col2) while slot full -> overrun, code stays 5
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd5, 1'b1, 1'b1));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd5, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd5, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C3, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C0, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C1, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    // key 6 again with key_ready on the offer cycle -> reload, no overrun
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd5, 1'b0, 1'b0));
    tbl.push_back(mk(R1, 1'b1, C2, 1'b1, 4'd6, 1'b1, 1'b0));
    // release bounce: high 1 tick, low, then high 3 ticks
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd6, 1'b1, 1'b0));
    tbl.push_back(mk(R1, 1'b0, C2, 1'b1, 4'd6, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd6, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C2, 1'b1, 4'd6, 1'b1, 1'b0));
    tbl.push_back(mk(NK, 1'b0, C3, 1'b1, 4'd6, 1'b0, 1'b0));
    tbl.push_back(mk(NK, 1'b1, C0, 1'b0, 4'd6, 1'b0, 1'b0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("reset col_n", 0, col_n, C0);
    chk("reset key_valid", 0, {3'b0, kif.key_valid}, 4'd0);
    chk("reset key_code", 0, kif.key_code, 4'd0);
    chk("reset key_held", 0, {3'b0, kif.key_held}, 4'd0);
    chk("reset overrun", 0, {3'b0, kif.overrun}, 4'd0);
    prev_col = C0;

    for (int i = 0; i < tbl.size(); i++) run_step(tbl[i], i + 1);

    // Reset mid-press: key 4 (row1,col0) in debounce, then reset.
    run_step(mk(R1, 1'b0, C0, 1'b0, 4'd6, 1'b0, 1'b0), 101);
    run_step(mk(R1, 1'b0, C0, 1'b0, 4'd6, 1'b0, 1'b0), 102);
    #2;
    reset_n = 1'b0;
    row_n   = NK;
    #1;
    chk("async reset col_n", 103, col_n, C0);
    chk("async reset key_code", 103, kif.key_code, 4'd0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    prev_col = C0;
    run_step(mk(NK, 1'b0, C1, 1'b0, 4'd0, 1'b0, 1'b0), 104);
    run_step(mk(NK, 1'b0, C2, 1'b0, 4'd0, 1'b0, 1'b0), 105);
    run_step(mk(NK, 1'b0, C3, 1'b0, 4'd0, 1'b0, 1'b0), 106);
    run_step(mk(NK, 1'b0, C0, 1'b0, 4'd0, 1'b0, 1'b0), 107);

    // Long hold of key 12 (row3,col0) with key_ready high: 15 low ticks
    // (detect, debounce, offer, then 12 ticks in PRESSED), 3 release ticks.
`ifdef KEYPAD_SCAN_REPEAT_EN
    exp_hs = 5;
`else
    exp_hs = 1;
`endif
    hs = 0;
    kif.key_ready = 1'b1;
    for (int t = 0; t < 18; t++) begin
      row_n = (t < 15) ? R3 : NK;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (kif.key_valid && kif.key_ready) hs++;
      end
    end
    kif.key_ready = 1'b0;
    chk("hold code count", 200, 4'(hs), 4'(exp_hs));
    chk("hold key_code", 200, kif.key_code, 4'd12);
    chk("hold key_held after release", 200, {3'b0, kif.key_held}, 4'd0);
    chk("hold col_n after release", 200, col_n, C1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad by driving one column low at a time and sampling the rows. It debounces a single key press and delivers a 4-bit key code through a valid/ready holding register. This is the input-side counterpart of the multiplexed seven-segment display output: the display drives patterns out to the board, and this block reads key presses in from it. It sits between the board I/O pins and the application logic.

## Interface
- SCAN_DIV, 50_000: clk cycles per scan tick (1 ms at 50 MHz); legal range is 2 or more.
- DB_CNT, 20: number of consecutive matching tick samples needed to accept a press or a release; legal range is 1 or more.
- REPEAT_DLY, 500: ticks a key must be held before auto-repeat starts. Used only with the macro.
- REPEAT_RATE, 100: ticks between repeated codes. Used only with the macro.
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- row_n  input  4  keypad rows, asynchronous, active-low, board pull-ups
- col_n  output  4  column drive, one-hot active-low
- key_code  output  4  accepted key, computed as row*4 + col
- key_valid  output  1  key_code holds an unconsumed key
- key_ready  input  1  consumer accepts key_code when this and key_valid are both high on a clk edge
- key_held  output  1  the debounced key is currently pressed
- overrun  output  1  one-cycle pulse when a key is dropped because the holding register is full

## Operation
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- The tick prescaler counts 0 to SCAN_DIV-1 and then wraps. `tick` is high in the cycle where the count equals SCAN_DIV-1.
- Sampling happens only on tick cycles, so each column has had SCAN_DIV-1 cycles to settle before its rows are read.
- The FSM has four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
- SCAN:
  - On tick with rs all high: advance the column index 0→1→2→3→0.
  - On tick with any rs bit low: latch the column and the lowest-index low row as the candidate, set db_cnt=1, freeze the column, and go to DEBOUNCE. If DB_CNT=1, go straight to PRESSED.
- DEBOUNCE:
  - On tick with the same row low: increment db_cnt. When db_cnt reaches DB_CNT, go to PRESSED and offer the key.
  - On tick with a different row pattern: go to SCAN on the same column, with no output.
- Offering a key:
  - If key_valid is low, or if key_valid and key_ready are both high in the same cycle: load key_code and set key_valid.
  - Otherwise: leave key_code unchanged and pulse overrun for one cycle.
- PRESSED:
  - key_held=1.
  - On tick with the candidate row high: db_cnt=1 and go to RELEASE.
- RELEASE:
  - On tick with the candidate row high: increment db_cnt. At DB_CNT, go to SCAN, advance the column, and set key_held=0.
  - On tick with the candidate row low: go back to PRESSED.
- key_valid clears on the clock edge after a cycle where key_valid and key_ready are both high. Reload takes priority over clear in the same cycle.
- Other keys pressed while one key is held are ignored until the release completes.

## Timing
- Reset values:
  - col_n=4'b1110 (column 0 driven low)
  - key_code=0, key_valid=0, key_held=0, overrun=0
  - state=SCAN, prescaler=0, db_cnt=0
- Asserting reset mid-press abandons the press; no code is emitted after reset.
- Synchronizer latency: 2 cycles.
- Press to key_valid: key_valid rises on the clk edge after the tick on which db_cnt reaches DB_CNT. This is DB_CNT-1 ticks after the first detecting tick.
- col_n updates on the edge after an advancing tick.
- All outputs are registered.

## Configuration
- Macro `KEYPAD_SCAN_REPEAT_EN` enables auto-repeat.
- With the macro defined:
  - In PRESSED, a repeat counter counts ticks.
  - After REPEAT_DLY ticks, the same key is offered again, then again every REPEAT_RATE ticks.
  - Repeats follow the same overrun rule as a normal offer.
  - The counter clears on entry to PRESSED. Moving PRESSED→RELEASE→PRESSED does not restart the delay.
- Without the macro: exactly one code is offered per press, and REPEAT_DLY and REPEAT_RATE are unused.

## Structure
- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED, RELEASE)
  - ROWS=4, COLS=4, KEY_W=4
  - the key-code mapping function
- One sub-module, `keypad_tick`, is the SCAN_DIV prescaler producing `tick`.
- The synchronizer, FSM and holding register stay in keypad_scan.

## Test plan
Benches use SCAN_DIV=4 and DB_CNT=3 throughout.
- Reset, no keys: col_n cycles 1110→1101→1011→0111→1110, changing once every 4 clk cycles. key_valid stays 0.
- Row 2 held low while column 1 is driven: the column freezes at 1101, then key_valid=1 with key_code=9 after 2 further ticks. key_held=1. After key_ready is asserted for 1 cycle, key_valid=0.
- Glitch: row 0 low for a single tick, then high → no key_valid, and scanning resumes.
- Overrun: with key_ready=0, press key 5, release it, then press key 6 → key_code stays 5 and overrun pulses once. With key_ready=1 on the offer cycle of key 6 instead, key_code=6 and there is no overrun.
- Release bounce: in PRESSED, row high for 1 tick, low, then high for 3 ticks → no duplicate code, and key_held falls only after the 3-tick release.
- With `KEYPAD_SCAN_REPEAT_EN`, REPEAT_DLY=5 and REPEAT_RATE=2, key_ready=1, one key held for 12 ticks → the code is emitted 1+4 times.
